alu_issue_queue: RTL

Upstream issue stage for `alu`: buffers operation commands (opcode plus two operands) from the decode side in a small synchronous FIFO. It presents one command per cycle on registered `OPCODE`/`OP1`/`OP2` outputs that connect directly to the matching `alu` inputs. It supports backpressure to the producer, a stall from downstream, and a synchronous flush.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 68 ++++++
 rtl/alu_issue_queue.sv | 78 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command types: field widths, the opcode set and the command record
// carried from decode through the issue queue into the ALU.
package alu_pkg;

  localparam int OPC_W = 3;
  localparam int OP_W  = 4;

  typedef enum logic [OPC_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [OP_W-1:0]  op1;
    logic [OP_W-1:0]  op2;
  } alu_cmd_t;

  function automatic alu_cmd_t make_cmd(input logic [OPC_W-1:0] opc,
                                        input logic [OP_W-1:0]  a,
                                        input logic [OP_W-1:0]  b);
    alu_cmd_t c;
    c.opcode = opc;
    c.op1    = a;
    c.op2    = b;
    return c;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO of ALU commands with occupancy count and flush.
// Caller must not push when full nor pop when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  alu_cmd_t         push_cmd,
  input  logic             pop,
  input  logic             flush,
  output alu_cmd_t         head_cmd,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  alu_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_cmd;
  end

  assign head_cmd = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of the ALU: buffers decoded commands and presents one
// per cycle on registered OPCODE/OP1/OP2 with stall hold and flush.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPC_W = 3,
  parameter int OP_W  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [OP_W-1:0]  in_op1,
  input  logic [OP_W-1:0]  in_op2,
  input  logic             stall,
  input  logic             flush,
  output logic [OPC_W-1:0] OPCODE,
  output logic [OP_W-1:0]  OP1,
  output logic [OP_W-1:0]  OP2,
  output logic             iss_vld,
  output logic [CNT_W-1:0] count
);

  alu_cmd_t   head_cmd;
  alu_cmd_t   iss_cmd_q, iss_cmd_d;
  logic       iss_vld_q, iss_vld_d;
  logic       fifo_full, fifo_empty;
  logic       push, pop;

  assign in_rdy = !fifo_full;
  assign push   = in_vld && in_rdy;
  assign pop    = !stall && !fifo_empty && !flush;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_cmd (make_cmd(in_opcode, in_op1, in_op2)),
    .pop      (pop),
    .flush    (flush),
    .head_cmd (head_cmd),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Flush wins over stall; an empty unstalled cycle drops valid but keeps data.
  always_comb begin
    iss_cmd_d = iss_cmd_q;
    iss_vld_d = iss_vld_q;
    if (flush) begin
      iss_cmd_d = '0;
      iss_vld_d = 1'b0;
    end else if (!stall) begin
      iss_vld_d = pop;
      if (pop) iss_cmd_d = head_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      iss_cmd_q <= '0;
      iss_vld_q <= 1'b0;
    end else begin
      iss_cmd_q <= iss_cmd_d;
      iss_vld_q <= iss_vld_d;
    end
  end

  assign OPCODE  = iss_cmd_q.opcode;
  assign OP1     = iss_cmd_q.op1;
  assign OP2     = iss_cmd_q.op2;
  assign iss_vld = iss_vld_q;

endmodule
